// File: rtl/mem_port_arbiter.sv
// Shares one SRAM port between fetch (read-only) and data (LW/SW) requesters; WAIT_CYCLES-cycle access then a one-cycle ack.
// Transfer latency is WAIT_CYCLES+2 cycles; requests are level-held until ack and stall covers every unserved request.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int SRAM_AW     = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [31:0]        if_addr,
  output logic [31:0]        if_rdata,
  output logic               if_ack,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_wdata,
  output logic [31:0]        mem_rdata,
  output logic               mem_ack,
  output logic               stall,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_wdata,
  input  logic [31:0]        sram_rdata,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  logic [1:0]         r_state;
  logic [3:0]         r_cnt;
  logic               r_last_mem;
  logic               r_gnt_mem;
  logic               r_we;
  logic               r_if_ack;
  logic               r_mem_ack;
  logic [31:0]        r_if_rdata;
  logic [31:0]        r_mem_rdata;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic [SRAM_AW-1:0] r_sram_addr;
  logic [31:0]        r_sram_wdata;

  logic        w_any_req;
  logic        w_gnt_mem;
  logic        w_gnt_we;
  logic [31:0] w_req_addr;
  logic        w_unused_addr;

  // On a tie the data port wins unless it was the one served last.
  assign w_any_req  = if_req | mem_req;
  assign w_gnt_mem  = mem_req & (~if_req | ~r_last_mem);
  assign w_gnt_we   = w_gnt_mem & mem_we;
  assign w_req_addr = w_gnt_mem ? mem_addr : if_addr;
  assign w_unused_addr = ^{w_req_addr[31:SRAM_AW+2], w_req_addr[1:0]};

  // Strobes are registered so the SRAM pins never see decode glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_mem   <= 1'b0;
      r_gnt_mem    <= 1'b0;
      r_we         <= 1'b0;
      r_if_ack     <= 1'b0;
      r_mem_ack    <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_mem_rdata  <= 32'd0;
      r_ce_n       <= 1'b1;
      r_oe_n       <= 1'b1;
      r_we_n       <= 1'b1;
      r_sram_addr  <= '0;
      r_sram_wdata <= 32'd0;
    end else begin
      r_if_ack  <= 1'b0;
      r_mem_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state     <= S_ACCESS;
            r_gnt_mem   <= w_gnt_mem;
            r_we        <= w_gnt_we;
            r_cnt       <= CNT_INIT;
            r_sram_addr <= w_req_addr[SRAM_AW+1:2];
            if (w_gnt_mem) begin
              r_sram_wdata <= mem_wdata;
            end
            r_ce_n <= 1'b0;
            r_oe_n <= w_gnt_we;
            r_we_n <= ~w_gnt_we;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            if (!r_we) begin
              if (r_gnt_mem) begin
                r_mem_rdata <= sram_rdata;
              end else begin
                r_if_rdata <= sram_rdata;
              end
            end
            r_if_ack  <= ~r_gnt_mem;
            r_mem_ack <= r_gnt_mem;
          end else begin
            r_cnt <= r_cnt - 4'd1;
            // Release we_n one cycle early so address/data outlive its rising edge.
            if (r_cnt == 4'd1) begin
              r_we_n <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state    <= S_IDLE;
          r_last_mem <= r_gnt_mem;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_ack     = r_if_ack;
  assign mem_ack    = r_mem_ack;
  assign if_rdata   = r_if_rdata;
  assign mem_rdata  = r_mem_rdata;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_addr  = r_sram_addr;
  assign sram_wdata = r_sram_wdata;
  assign stall      = (if_req & ~r_if_ack) | (mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/timing cases plus random traffic against a transaction-level model.
// A second instance with WAIT_CYCLES=4 checks back-to-back fetch timing.
module tb_mem_port_arbiter;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_req, mem_we;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, sram_wdata, sram_rdata;
  logic        if_ack, mem_ack, stall, sram_ce_n, sram_oe_n, sram_we_n;
  logic [19:0] sram_addr;

  logic        if_req4;
  logic [31:0] if_addr4;
  logic        mem_req4, mem_we4;
  logic [31:0] mem_addr4, mem_wdata4;
  logic [31:0] if_rdata4, mem_rdata4, sram_wdata4, sram_rdata4;
  logic        if_ack4, mem_ack4, stall4, sram_ce_n4, sram_oe_n4, sram_we_n4;
  logic [19:0] sram_addr4;

  logic [31:0] sram_arr [256];
  logic [31:0] ref_mem  [256];
  bit          sram_loaded;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [7:0] i);
    if (i == 8'd4) return 32'hDEADBEEF;
    return {i, 8'h5A, ~i, 8'hC3};
  endfunction

  always @(posedge clk) begin
    if (!sram_loaded) begin
      for (int i = 0; i < 256; i++) sram_arr[i] <= init_word(8'(i));
    end else if (!sram_ce_n && !sram_we_n) begin
      sram_arr[sram_addr[7:0]] <= sram_wdata;
    end
  end
  assign sram_rdata  = (!sram_ce_n && !sram_oe_n) ? sram_arr[sram_addr[7:0]] : 32'hBADC0DE0;
  assign sram_rdata4 = (!sram_ce_n4 && !sram_oe_n4) ? init_word(sram_addr4[7:0]) : 32'hBADC0DE0;

  mem_port_arbiter #(.WAIT_CYCLES(W), .SRAM_AW(20)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall),
    .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
  );

  mem_port_arbiter #(.WAIT_CYCLES(4), .SRAM_AW(20)) dut4 (
    .clk(clk), .rst(rst),
    .if_req(if_req4), .if_addr(if_addr4), .if_rdata(if_rdata4), .if_ack(if_ack4),
    .mem_req(mem_req4), .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .mem_rdata(mem_rdata4), .mem_ack(mem_ack4), .stall(stall4),
    .sram_addr(sram_addr4), .sram_wdata(sram_wdata4), .sram_rdata(sram_rdata4),
    .sram_ce_n(sram_ce_n4), .sram_oe_n(sram_oe_n4), .sram_we_n(sram_we_n4)
  );

  // Staged stimulus, applied just after each rising edge.
  logic        s_if_req, s_mem_req, s_mem_we;
  logic [31:0] s_if_addr, s_mem_addr, s_mem_wdata;

  // Transaction-level model: one outstanding transfer described by its grant cycle.
  int          cyc;
  bit          m_busy, m_gmem, m_gwe, m_last_mem;
  int          m_gcyc;
  logic [19:0] m_gaddr;
  logic [7:0]  m_gidx;
  logic [31:0] m_gwdata, m_if_rd, m_mem_rd;
  bit          ack_if_now, ack_mem_now;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_last_mem = 1'b0; m_if_rd = 32'd0; m_mem_rd = 32'd0; cyc = 0;
  endtask

  task automatic tick_check();
    bit acc, done, e_if_ack, e_mem_ack;
    logic [31:0] a;
    acc  = m_busy && (cyc >= m_gcyc + 1) && (cyc <= m_gcyc + W);
    done = m_busy && (cyc == m_gcyc + W + 1);
    if (done && !m_gwe) begin
      if (m_gmem) m_mem_rd = ref_mem[m_gidx];
      else        m_if_rd  = ref_mem[m_gidx];
    end
    if (done && m_gwe) ref_mem[m_gidx] = m_gwdata;
    e_if_ack  = done && !m_gmem;
    e_mem_ack = done && m_gmem;
    chk("if_ack",  32'(if_ack),  32'(e_if_ack));
    chk("mem_ack", 32'(mem_ack), 32'(e_mem_ack));
    chk("ce_n", 32'(sram_ce_n), 32'(!acc));
    chk("oe_n", 32'(sram_oe_n), 32'(!(acc && !m_gwe)));
    chk("we_n", 32'(sram_we_n), 32'(!(acc && m_gwe && (cyc <= m_gcyc + W - 1))));
    if (acc) chk("sram_addr", 32'(sram_addr), 32'(m_gaddr));
    if (acc && m_gwe) chk("sram_wdata", sram_wdata, m_gwdata);
    if (done && m_gwe) chk("sram_word", sram_arr[m_gidx], m_gwdata);
    chk("if_rdata",  if_rdata,  m_if_rd);
    chk("mem_rdata", mem_rdata, m_mem_rd);
    chk("stall", 32'(stall), 32'((if_req && !e_if_ack) || (mem_req && !e_mem_ack)));
    ack_if_now  = e_if_ack;
    ack_mem_now = e_mem_ack;
    if (!(m_busy && cyc <= m_gcyc + W + 1) && (if_req || mem_req)) begin
      m_gmem     = mem_req && (!if_req || !m_last_mem);
      m_last_mem = m_gmem;
      m_busy     = 1'b1;
      m_gcyc     = cyc;
      m_gwe      = m_gmem && mem_we;
      a          = m_gmem ? mem_addr : if_addr;
      m_gaddr    = a[21:2];
      m_gidx     = a[9:2];
      m_gwdata   = mem_wdata;
    end
    cyc++;
  endtask

  task automatic apply();
    if_req = s_if_req; if_addr = s_if_addr;
    mem_req = s_mem_req; mem_we = s_mem_we; mem_addr = s_mem_addr; mem_wdata = s_mem_wdata;
  endtask

  task automatic step();
    @(posedge clk); #1;
    apply();
    @(negedge clk);
    tick_check();
  endtask

  task automatic run_until_ack(input bit want_mem, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if ((want_mem ? mem_ack : if_ack) === 1'b1) begin
        at = cyc - 1;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom();
    r[21:6] = 16'h0;
    return r;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_ack"},  32'(if_ack),    32'd0);
    chk({tag, "_mem_ack"}, 32'(mem_ack),   32'd0);
    chk({tag, "_ce_n"},    32'(sram_ce_n), 32'd1);
    chk({tag, "_oe_n"},    32'(sram_oe_n), 32'd1);
    chk({tag, "_we_n"},    32'(sram_we_n), 32'd1);
  endtask

  initial begin
    int at;
    bit dropped_if, dropped_mem, granted;
    rst = 1'b0; sram_loaded = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    s_if_req = 1'b1; s_if_addr = 32'h0000_0010;
    s_mem_req = 1'b0; s_mem_we = 1'b0; s_mem_addr = 32'd0; s_mem_wdata = 32'd0;
    apply();
    if_req4 = 1'b0; if_addr4 = 32'd0; mem_req4 = 1'b0; mem_we4 = 1'b0;
    mem_addr4 = 32'd0; mem_wdata4 = 32'd0;
    repeat (3) @(posedge clk);
    sram_loaded = 1'b1;
    @(negedge clk);
    chk_reset_outputs("rst");
    chk("rst_stall", 32'(stall), 32'd1);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_sram_addr", 32'(sram_addr), 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);

    // Release with a fetch pending: this cycle is cycle 0.
    rst = 1'b1; model_reset(); tick_check();
    run_until_ack(1'b0, at);
    chk("if_read_ack_cyc", 32'(at), 32'd3);
    chk("if_read_data", if_rdata, 32'hDEADBEEF);
    s_if_req = 1'b0;

    s_mem_req = 1'b1; s_mem_we = 1'b1; s_mem_addr = 32'h0000_0100; s_mem_wdata = 32'h12345678;
    run_until_ack(1'b1, at);
    chk("sw_ack_cyc", 32'(at), 32'd7);
    chk("sw_word40", sram_arr[8'h40], 32'h12345678);
    s_mem_req = 1'b0; s_mem_we = 1'b0;
    step();

    // Reset, then both ports request together and keep requesting.
    @(posedge clk); #1;
    rst = 1'b0;
    s_if_req = 1'b1; s_if_addr = 32'h0000_0014;
    s_mem_req = 1'b1; s_mem_addr = 32'h0000_0100;
    apply();
    @(negedge clk);
    chk_reset_outputs("rst2");
    rst = 1'b1; model_reset(); tick_check();
    run_until_ack(1'b1, at);
    chk("tie_mem_first", 32'(at), 32'd3);
    chk("tie_mem_data", mem_rdata, 32'h12345678);
    run_until_ack(1'b0, at);
    chk("tie_if_second", 32'(at), 32'd7);
    run_until_ack(1'b1, at);
    chk("tie_mem_third", 32'(at), 32'd11);
    s_if_req = 1'b0; s_mem_req = 1'b0;
    step();

    // Reset arriving in the first access cycle abandons the transfer.
    s_if_req = 1'b1; s_if_addr = 32'h0000_0018;
    step();
    step();
    chk("mid_ce_low", 32'(sram_ce_n), 32'd0);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs("mid_hold");
    rst = 1'b1; model_reset(); tick_check();
    run_until_ack(1'b0, at);
    chk("restart_ack_cyc", 32'(at), 32'd3);
    chk("restart_data", if_rdata, init_word(8'd6));
    s_if_req = 1'b0;
    step();

    // Random traffic; requesters hold until ack and may drop once granted.
    dropped_if = 1'b0; dropped_mem = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      step();
      granted = m_busy && !m_gmem && (cyc > m_gcyc) && (cyc <= m_gcyc + W);
      if (ack_if_now) begin
        dropped_if = 1'b0;
        if ($urandom_range(0, 1) == 0) begin s_if_req = 1'b1; s_if_addr = rand_addr(); end
        else s_if_req = 1'b0;
      end else if (!s_if_req && !dropped_if) begin
        if ($urandom_range(0, 2) == 0) begin s_if_req = 1'b1; s_if_addr = rand_addr(); end
      end else if (s_if_req && granted && $urandom_range(0, 7) == 0) begin
        s_if_req = 1'b0; dropped_if = 1'b1;
      end
      granted = m_busy && m_gmem && (cyc > m_gcyc) && (cyc <= m_gcyc + W);
      if (ack_mem_now || (!s_mem_req && !dropped_mem)) begin
        if (ack_mem_now) dropped_mem = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          s_mem_req = 1'b1; s_mem_addr = rand_addr();
          s_mem_we = 1'($urandom_range(0, 1)); s_mem_wdata = $urandom();
        end else s_mem_req = 1'b0;
      end else if (s_mem_req && granted && $urandom_range(0, 7) == 0) begin
        s_mem_req = 1'b0; dropped_mem = 1'b1;
      end
    end
    s_if_req = 1'b0; s_mem_req = 1'b0;
    repeat (6) step();

    // WAIT_CYCLES=4 instance: fetch held high for two back-to-back reads.
    @(posedge clk); #1;
    if_req4 = 1'b1; if_addr4 = 32'h0000_0020;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      chk("w4_ack", 32'(if_ack4), 32'(c == 5 || c == 11));
      chk("w4_oe_n", 32'(sram_oe_n4), 32'(!((c >= 1 && c <= 4) || (c >= 7 && c <= 10))));
      if (c == 5)  chk("w4_data0", if_rdata4, init_word(8'd8));
      if (c == 11) chk("w4_data1", if_rdata4, init_word(8'd9));
      @(posedge clk); #1;
      if (c == 5)  if_addr4 = 32'h0000_0024;
      if (c == 11) if_req4 = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single off-chip SRAM port between the instruction-fetch stage (read-only) and the memory stage (LW/SW).
- Each access is sequenced through a fixed wait-state FSM that drives the SRAM control strobes.
- Requesters get a per-port ack; a combined stall output freezes the pipeline while any accepted or pending request is unserved.
- Sits between stage_if/stage_mem and the board SRAM pins.

Parameters:
- WAIT_CYCLES, 2, SRAM access cycles per transfer; legal range 2..15.
- SRAM_AW, 20, SRAM word-address width; maps to byte address bits [SRAM_AW+1:2].

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch read request, level; held until if_ack.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetch read data; valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse for the fetch port.
- mem_req  in  1  data request, level; held until mem_ack.
- mem_we  in  1  1 = store (SW), 0 = load (LW).
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  store data.
- mem_rdata  out  32  load data; valid while mem_ack=1.
- mem_ack  out  1  one-cycle completion pulse for the data port.
- stall  out  1  combinational: (if_req & ~if_ack) | (mem_req & ~mem_ack).
- sram_addr  out  SRAM_AW  SRAM word address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- sram_ce_n  out  1  chip enable, active low.
- sram_oe_n  out  1  output enable, active low.
- sram_we_n  out  1  write enable, active low.

Behaviour:
- Reset (rst=0, async): state=IDLE; counter=0; last_grant=IF, so the MEM port wins the first tie.
- Reset values of outputs: if_ack=0, mem_ack=0, if_rdata=0, mem_rdata=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0, sram_wdata=0.
- Reset mid-access: the strobes deassert immediately (asynchronously) and the in-flight transfer is abandoned with no ack.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE.
  - Only one request: grant that port.
  - Both requests: grant the port that was not granted last.
  - On grant, at the posedge: register sram_addr = addr[SRAM_AW+1:2]; register sram_wdata = mem_wdata for MEM; record grant and direction; set counter = WAIT_CYCLES-1; go to ACCESS.
  - addr[1:0] is ignored (word access only).
- ACCESS (exactly WAIT_CYCLES cycles):
  - sram_ce_n=0 throughout.
  - Read: sram_oe_n=0 throughout.
  - Write: sram_we_n=0 in every ACCESS cycle except the last, so address and data hold one cycle past the we_n rising edge.
  - Counter decrements each posedge. At the posedge where counter==0: a read latches sram_rdata into the granted port's rdata register; state goes to DONE.
- DONE (1 cycle):
  - All strobes high.
  - The granted port's ack=1; its rdata holds the latched value (unchanged for writes).
  - last_grant updates; next state is IDLE.
- Requests are sampled only in IDLE. A requester that keeps req high after its ack starts a new transfer at the next IDLE.
- A req that drops while ACCESS is in progress does not abort the transfer; the ack still pulses.
- Latency: req present in IDLE cycle 0 → ACCESS cycles 1..WAIT_CYCLES → ack in cycle WAIT_CYCLES+1 → IDLE in cycle WAIT_CYCLES+2. The minimum period per transfer is WAIT_CYCLES+2 cycles.
- The ungranted port's ack stays 0 and its rdata register is unchanged.
- Only one of if_ack/mem_ack is ever high in a given cycle.

Test Plan:
- Reset: hold rst=0 with if_req=1 → all acks 0, strobes 1, stall=1; release → IF granted, if_ack in cycle 3 (WAIT_CYCLES=2).
- IF read alone: if_addr=0x0000_0010, SRAM word 4 = 0xDEADBEEF → sram_addr=4, oe_n low 2 cycles, if_ack=1 with if_rdata=0xDEADBEEF in cycle 3, stall=0 in that cycle.
- SW: mem_we=1, mem_addr=0x0000_0100, mem_wdata=0x12345678 → sram_addr=0x40, we_n low for cycle 1 only, ce_n low for cycles 1-2, mem_ack in cycle 3, SRAM word 0x40 = 0x12345678.
- Simultaneous requests after reset: MEM LW served first (mem_ack in cycle 3), IF served next (if_ack in cycle 7); repeating both requests alternates the grant.
- Async reset asserted in cycle 1 of ACCESS → strobes go high before the next posedge; no ack is produced; after release a pending req restarts from IDLE.
- WAIT_CYCLES=4 with back-to-back IF reads (req held high) → acks in cycles 5 and 11; oe_n low for 4 cycles each transfer.
